// File: rtl/wb_buffer.sv
// Write-back buffer: queues evicted dirty blocks, coalesces repeat evictions of the
// same block, issues stores to memory, answers load lookups and drains on flush.
module wb_buffer #(
   parameter int DEPTH       = 4,
   parameter int MEM_IDX_LEN = 16,
   parameter int BLK_W       = 32,
   parameter int TAG_W       = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   evict_valid,
   input  logic [MEM_IDX_LEN-1:0] evict_idx,
   input  logic [BLK_W-1:0]       evict_blk,
   output logic                   evict_ready,
   input  logic                   lkp_valid,
   input  logic [MEM_IDX_LEN-1:0] lkp_idx,
   output logic                   lkp_hit,
   output logic [BLK_W-1:0]       lkp_blk,
   output logic [1:0]             mem_qry_cmd,
   output logic [MEM_IDX_LEN-1:0] mem_qry_idx,
   output logic [BLK_W-1:0]       mem_qry_blk,
   input  logic [TAG_W-1:0]       mem_ack,
   input  logic                   flush_req,
   output logic                   flush_done,
   output logic                   overflow
);
   localparam int IDX_LEN = $clog2(DEPTH);
   localparam logic [IDX_LEN:0] FULL_CNT = (IDX_LEN+1)'(DEPTH);
   localparam logic [1:0] MEM_CMD_NONE  = 2'd0;
   localparam logic [1:0] MEM_CMD_STORE = 2'd2;

   typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

   logic [MEM_IDX_LEN-1:0] idxMem_q [DEPTH];
   logic [BLK_W-1:0]       blkMem_q [DEPTH];
   logic [IDX_LEN-1:0]     head_q, head_d, tail_q, tail_d;
   logic [IDX_LEN:0]       count_q, count_d;
   state_t                 state_q, state_d;
   logic                   overflow_q, overflow_d;

   logic                   full, empty, pop, push, coalesce, dropBlk;
   logic [DEPTH-1:0]       entryValid;
   logic [IDX_LEN-1:0]     coalIdx, offs;

   assign full        = (count_q == FULL_CNT);
   assign empty       = (count_q == '0);
   assign pop         = !empty && (mem_ack != '0);
   assign evict_ready = !full && (state_q != DRAIN);
   assign overflow    = overflow_q;

   // An entry is live when its distance from head is below count; a match on the head
   // that is retiring this cycle must not absorb the new data, so it becomes a fresh push.
   always_comb begin
      entryValid = '0;
      offs       = '0;
      coalesce   = 1'b0;
      coalIdx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs          = IDX_LEN'(i) - head_q;
         entryValid[i] = ({1'b0, offs} < count_q);
         if (evict_valid && entryValid[i] && (idxMem_q[i] == evict_idx) &&
             !(pop && (IDX_LEN'(i) == head_q))) begin
            coalesce = 1'b1;
            coalIdx  = IDX_LEN'(i);
         end
      end
      push    = evict_valid && !coalesce && evict_ready;
      dropBlk = evict_valid && !coalesce && !evict_ready;
   end

   // The evict port is checked last so its data, being newest, overrides a buffered copy.
   always_comb begin
      lkp_hit = 1'b0;
      lkp_blk = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (lkp_valid && entryValid[i] && (idxMem_q[i] == lkp_idx)) begin
            lkp_hit = 1'b1;
            lkp_blk = blkMem_q[i];
         end
      end
      if (lkp_valid && evict_valid && (evict_idx == lkp_idx)) begin
         lkp_hit = 1'b1;
         lkp_blk = evict_blk;
      end
   end

   always_comb begin
      mem_qry_cmd = MEM_CMD_NONE;
      mem_qry_idx = '0;
      mem_qry_blk = '0;
      if (!empty) begin
         mem_qry_cmd = MEM_CMD_STORE;
         mem_qry_idx = idxMem_q[head_q];
         mem_qry_blk = blkMem_q[head_q];
      end
   end

   always_comb begin
      state_d    = state_q;
      flush_done = 1'b0;
      head_d     = pop  ? head_q + 1'b1 : head_q;
      tail_d     = push ? tail_q + 1'b1 : tail_q;
      count_d    = count_q + {{IDX_LEN{1'b0}}, push} - {{IDX_LEN{1'b0}}, pop};
      overflow_d = overflow_q | dropBlk;
      case (state_q)
         IDLE:    if (flush_req) state_d = DRAIN;
         DRAIN:   if (empty && !push) state_d = DONE;
         DONE: begin
            flush_done = 1'b1;
            state_d    = flush_req ? DRAIN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         state_q    <= IDLE;
         overflow_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            idxMem_q[i] <= '0;
            blkMem_q[i] <= '0;
         end
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         state_q    <= state_d;
         overflow_q <= overflow_d;
         if (coalesce) blkMem_q[coalIdx] <= evict_blk;
         if (push) begin
            idxMem_q[tail_q] <= evict_idx;
            blkMem_q[tail_q] <= evict_blk;
         end
      end
   end
endmodule

// File: tb/tb_wb_buffer.sv
// Directed bench for wb_buffer: each task drives one scenario and checks ports inline.
module tb_wb_buffer;
   localparam logic [1:0] NONE  = 2'd0;
   localparam logic [1:0] STORE = 2'd2;

   logic        clock, reset;
   logic        evict_valid, evict_ready, lkp_valid, lkp_hit;
   logic [15:0] evict_idx, lkp_idx, mem_qry_idx;
   logic [31:0] evict_blk, lkp_blk, mem_qry_blk;
   logic [1:0]  mem_qry_cmd;
   logic [3:0]  mem_ack;
   logic        flush_req, flush_done, overflow;
   int          total = 0;
   int          bad   = 0;

   wb_buffer dut (
      .clock(clock), .reset(reset),
      .evict_valid(evict_valid), .evict_idx(evict_idx), .evict_blk(evict_blk),
      .evict_ready(evict_ready),
      .lkp_valid(lkp_valid), .lkp_idx(lkp_idx), .lkp_hit(lkp_hit), .lkp_blk(lkp_blk),
      .mem_qry_cmd(mem_qry_cmd), .mem_qry_idx(mem_qry_idx), .mem_qry_blk(mem_qry_blk),
      .mem_ack(mem_ack), .flush_req(flush_req), .flush_done(flush_done),
      .overflow(overflow)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Advances to one time unit past the next rising edge.
   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic setIdle();
      evict_valid = 1'b0; evict_idx = '0; evict_blk = '0;
      lkp_valid = 1'b0; lkp_idx = '0; mem_ack = '0; flush_req = 1'b0;
   endtask

   task automatic evict(input logic [15:0] idx, input logic [31:0] blk);
      evict_valid = 1'b1; evict_idx = idx; evict_blk = blk;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      setIdle();
      lkp_valid = 1'b1; lkp_idx = 16'h0010;
      cycle(); cycle();
      total++; if (evict_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b want=1", evict_ready); end
      total++; if (mem_qry_cmd !== NONE) begin bad++; $display("FAIL rst_cmd got=%0d want=0", mem_qry_cmd); end
      total++; if (mem_qry_idx !== 16'h0 || mem_qry_blk !== 32'h0) begin bad++; $display("FAIL rst_qry got=%h/%h want=0/0", mem_qry_idx, mem_qry_blk); end
      total++; if (lkp_hit !== 1'b0) begin bad++; $display("FAIL rst_lkp got=%0b want=0", lkp_hit); end
      total++; if (flush_done !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL rst_flags got=%0b/%0b want=0/0", flush_done, overflow); end
      reset = 1'b1;
      setIdle();
      cycle();
   endtask

   task automatic test_basic();
      evict(16'h0010, 32'hAAAA_0001);
      cycle();
      setIdle();
      #1;
      total++; if (mem_qry_cmd !== STORE || mem_qry_idx !== 16'h0010 || mem_qry_blk !== 32'hAAAA_0001) begin bad++; $display("FAIL basic_issue got=%0d/%h/%h want=2/0010/aaaa0001", mem_qry_cmd, mem_qry_idx, mem_qry_blk); end
      mem_ack = 4'd1;
      cycle();
      mem_ack = '0;
      #1;
      total++; if (mem_qry_cmd !== NONE) begin bad++; $display("FAIL basic_pop got=%0d want=0", mem_qry_cmd); end
   endtask

   task automatic test_coalesce();
      evict(16'h0010, 32'hAAAA_0001);
      cycle();
      evict(16'h0010, 32'hBBBB_0002);
      cycle();
      setIdle();
      lkp_valid = 1'b1; lkp_idx = 16'h0010;
      #1;
      total++; if (lkp_hit !== 1'b1 || lkp_blk !== 32'hBBBB_0002) begin bad++; $display("FAIL coal_lkp got=%0b/%h want=1/bbbb0002", lkp_hit, lkp_blk); end
      total++; if (mem_qry_cmd !== STORE || mem_qry_blk !== 32'hBBBB_0002) begin bad++; $display("FAIL coal_store got=%0d/%h want=2/bbbb0002", mem_qry_cmd, mem_qry_blk); end
      mem_ack = 4'd1;
      cycle();
      setIdle();
      #1;
      total++; if (mem_qry_cmd !== NONE) begin bad++; $display("FAIL coal_count got=%0d want=0", mem_qry_cmd); end
   endtask

   task automatic test_full();
      for (int k = 0; k < 4; k++) begin
         evict(16'h0011 + 16'(k), 32'hD000_0000 + 32'(k));
         cycle();
      end
      setIdle();
      #1;
      total++; if (evict_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b want=0", evict_ready); end
      evict(16'h0050, 32'hEEEE_EEEE);
      cycle();
      setIdle();
      lkp_valid = 1'b1; lkp_idx = 16'h0050;
      #1;
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_ovf got=%0b want=1", overflow); end
      total++; if (lkp_hit !== 1'b0 || lkp_blk !== 32'h0) begin bad++; $display("FAIL full_lkp got=%0b/%h want=0/0", lkp_hit, lkp_blk); end
      lkp_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mem_ack = 4'd2;
         #1;
         total++; if (mem_qry_cmd !== STORE || mem_qry_idx !== 16'h0011 + 16'(k) || mem_qry_blk !== 32'hD000_0000 + 32'(k)) begin bad++; $display("FAIL full_order%0d got=%0d/%h/%h", k, mem_qry_cmd, mem_qry_idx, mem_qry_blk); end
         cycle();
      end
      setIdle();
      #1;
      total++; if (mem_qry_cmd !== NONE || evict_ready !== 1'b1 || overflow !== 1'b1) begin bad++; $display("FAIL full_empty got=%0d/%0b/%0b want=0/1/1", mem_qry_cmd, evict_ready, overflow); end
   endtask

   task automatic test_back_to_back();
      evict(16'h0020, 32'h0000_1234);
      cycle();
      evict(16'h0020, 32'hC0C0_C0C0);
      mem_ack = 4'd1;
      lkp_valid = 1'b1; lkp_idx = 16'h0020;
      #1;
      total++; if (mem_qry_idx !== 16'h0020 || mem_qry_blk !== 32'h0000_1234) begin bad++; $display("FAIL b2b_old got=%h/%h want=0020/00001234", mem_qry_idx, mem_qry_blk); end
      total++; if (lkp_hit !== 1'b1 || lkp_blk !== 32'hC0C0_C0C0) begin bad++; $display("FAIL b2b_lkp got=%0b/%h want=1/c0c0c0c0", lkp_hit, lkp_blk); end
      cycle();
      setIdle();
      #1;
      total++; if (mem_qry_cmd !== STORE || mem_qry_idx !== 16'h0020 || mem_qry_blk !== 32'hC0C0_C0C0) begin bad++; $display("FAIL b2b_new got=%0d/%h/%h want=2/0020/c0c0c0c0", mem_qry_cmd, mem_qry_idx, mem_qry_blk); end
      mem_ack = 4'd1;
      cycle();
      setIdle();
      #1;
      total++; if (mem_qry_cmd !== NONE) begin bad++; $display("FAIL b2b_count got=%0d want=0", mem_qry_cmd); end
   endtask

   task automatic test_flush();
      logic [4:0]  readyExp = 5'b11000;
      logic [4:0]  doneExp  = 5'b01000;
      logic [4:0]  storeExp = 5'b00011;
      evict(16'h0031, 32'h3100_0000); cycle();
      evict(16'h0032, 32'h3200_0000); cycle();
      evict(16'h0033, 32'h3300_0000); cycle();
      setIdle();
      flush_req = 1'b1; mem_ack = 4'd1;
      #1;
      total++; if (mem_qry_idx !== 16'h0031) begin bad++; $display("FAIL flush_head got=%h want=0031", mem_qry_idx); end
      cycle();
      flush_req = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         total++; if (evict_ready !== readyExp[c] || flush_done !== doneExp[c]) begin bad++; $display("FAIL flush_c%0d ready/done got=%0b/%0b want=%0b/%0b", c + 1, evict_ready, flush_done, readyExp[c], doneExp[c]); end
         total++; if (mem_qry_cmd !== (storeExp[c] ? STORE : NONE)) begin bad++; $display("FAIL flush_cmd_c%0d got=%0d want=%0d", c + 1, mem_qry_cmd, storeExp[c] ? STORE : NONE); end
         cycle();
      end
      setIdle();
   endtask

   task automatic test_reset_drain();
      evict(16'h0041, 32'h4100_0000); cycle();
      evict(16'h0042, 32'h4200_0000); cycle();
      setIdle();
      flush_req = 1'b1;
      cycle();
      flush_req = 1'b0;
      #1;
      total++; if (evict_ready !== 1'b0 || mem_qry_idx !== 16'h0041) begin bad++; $display("FAIL rd_drain got=%0b/%h want=0/0041", evict_ready, mem_qry_idx); end
      reset = 1'b0;
      lkp_valid = 1'b1; lkp_idx = 16'h0041;
      #1;
      total++; if (mem_qry_cmd !== NONE || evict_ready !== 1'b1 || overflow !== 1'b0 || lkp_hit !== 1'b0) begin bad++; $display("FAIL rd_async got=%0d/%0b/%0b/%0b want=0/1/0/0", mem_qry_cmd, evict_ready, overflow, lkp_hit); end
      reset = 1'b1;
      lkp_valid = 1'b0;
      mem_ack = 4'd3;
      for (int c = 0; c < 4; c++) begin
         #1;
         total++; if (flush_done !== 1'b0 || mem_qry_cmd !== NONE || evict_ready !== 1'b1) begin bad++; $display("FAIL rd_after%0d got=%0b/%0d/%0b want=0/0/1", c, flush_done, mem_qry_cmd, evict_ready); end
         cycle();
         mem_ack = '0;
      end
      evict(16'h0055, 32'h5555_5555);
      cycle();
      setIdle();
      #1;
      total++; if (mem_qry_cmd !== STORE || mem_qry_idx !== 16'h0055) begin bad++; $display("FAIL rd_push got=%0d/%h want=2/0055", mem_qry_cmd, mem_qry_idx); end
      mem_ack = 4'd1;
      cycle();
      setIdle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_coalesce();
      test_full();
      test_back_to_back();
      test_flush();
      test_reset_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
